jtframe_nmi_wdog: RTL and testbench

//  Parametrised NMI generator and watchdog for jtframe CPU boards. Successor to the fixed

---
 rtl/jtframe_nmi_wdog.sv | 110 +++++++++++
 tb/tb_jtframe_nmi_wdog.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jtframe_nmi_wdog.sv
// rtl/jtframe_nmi_wdog.sv - multi-source NMI generator with watchdog and stretched CPU reset
module jtframe_nmi_wdog #(
  parameter int NSRC = 1,
  parameter int WDW  = 4,
  parameter int RSTW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [NSRC-1:0] src,
  input  logic            en_we,
  input  logic [NSRC-1:0] en_din,
  input  logic [NSRC-1:0] ack,
  input  logic            tick,
  input  logic            kick,
  input  logic            wd_en,
  output logic            nmi_n,
  output logic [NSRC-1:0] pending,
  output logic [WDW-1:0]  wd_cnt,
  output logic            wd_rst
);

  localparam int SW = $clog2(RSTW + 1);

  typedef enum logic [1:0] {IDLE, COUNT, PULSE} state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] src_l, enable, enable_nx, pending_nx, edges;
  logic            tick_l, tick_edge;
  logic [WDW-1:0]  cnt, cnt_nx;
  logic [SW-1:0]   st, st_nx;

  assign edges     = src & ~src_l;
  assign tick_edge = tick & ~tick_l;

  // Enable is resolved first so a same-cycle write gates the new set; set beats ack.
  always_comb begin
    enable_nx  = enable;
    pending_nx = pending;
    if (state == PULSE) begin
      enable_nx  = '0;
      pending_nx = '0;
    end else if (cen) begin
      if (en_we) enable_nx = en_din;
      pending_nx = enable_nx & (edges | (pending & ~ack));
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    st_nx    = st;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (cen && wd_en) state_nx = COUNT;
      end
      COUNT: begin
        if (cen) begin
          if (!wd_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (kick) begin
            cnt_nx = '0;
          end else if (tick_edge) begin
            cnt_nx = cnt + 1'b1;
            if (&cnt) begin
              state_nx = PULSE;
              st_nx    = SW'(RSTW);
            end
          end
        end
      end
      PULSE: begin
        // the stretch runs on raw clk so the CPU sees a fixed-length reset
        cnt_nx = '0;
        st_nx  = st - 1'b1;
        if (st == SW'(1)) state_nx = wd_en ? COUNT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      st      <= '0;
      enable  <= '0;
      pending <= '0;
      src_l   <= '1;
      tick_l  <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      st      <= st_nx;
      enable  <= enable_nx;
      pending <= pending_nx;
      if (cen) begin
        src_l  <= src;
        tick_l <= tick;
      end
    end
  end

  assign nmi_n  = ~|pending;
  assign wd_cnt = cnt;
  assign wd_rst = (state == PULSE);

endmodule

// File: tb/tb_jtframe_nmi_wdog.sv
// tb/tb_jtframe_nmi_wdog.sv - scoreboard bench for jtframe_nmi_wdog (NSRC=2, WDW=4, RSTW=3)
module tb_jtframe_nmi_wdog;

  logic       clk = 1'b0;
  logic       rst, cen, en_we, tick, kick, wd_en;
  logic [1:0] src, en_din, ack;
  logic       nmi_n, wd_rst;
  logic [1:0] pending;
  logic [3:0] wd_cnt;

  jtframe_nmi_wdog #(.NSRC(2), .WDW(4), .RSTW(3)) dut (
    .clk(clk), .rst(rst), .cen(cen), .src(src), .en_we(en_we), .en_din(en_din),
    .ack(ack), .tick(tick), .kick(kick), .wd_en(wd_en), .nmi_n(nmi_n),
    .pending(pending), .wd_cnt(wd_cnt), .wd_rst(wd_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] pend;
    logic       nmi;
    logic [3:0] cnt;
    logic       wrst;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ncyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != ncyc) begin
        errors++;
        $display("FAIL %s: slot %0d missed, now %0d", e.name, e.cyc, ncyc);
      end else if (e.kind == 0) begin
        if (pending !== e.pend || nmi_n !== e.nmi) begin
          errors++;
          $display("FAIL %s: pending=%b nmi_n=%b, required pending=%b nmi_n=%b",
                   e.name, pending, nmi_n, e.pend, e.nmi);
        end
      end else begin
        if (wd_cnt !== e.cnt || wd_rst !== e.wrst) begin
          errors++;
          $display("FAIL %s: wd_cnt=%0d wd_rst=%b, required wd_cnt=%0d wd_rst=%b",
                   e.name, wd_cnt, wd_rst, e.cnt, e.wrst);
        end
      end
    end
    ncyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_n(input string nm, input logic [1:0] p, input logic n);
    exp_t x;
    x.cyc = ncyc; x.kind = 0; x.pend = p; x.nmi = n; x.cnt = '0; x.wrst = 1'b0; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic exp_w(input string nm, input logic [3:0] c, input logic r);
    exp_t x;
    x.cyc = ncyc; x.kind = 1; x.pend = '0; x.nmi = 1'b1; x.cnt = c; x.wrst = r; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step();
    tick = 1'b0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cen = 1'b1; src = 2'b11; en_we = 1'b0; en_din = 2'b00;
    ack = 2'b00; tick = 1'b0; kick = 1'b0; wd_en = 1'b0;
    step(); step();
    exp_n("rst_nmi", 2'b00, 1'b1);
    exp_w("rst_wd", 4'd0, 1'b0);

    // level already high at release is not an edge
    rst = 1'b0; step(); exp_n("rel_level", 2'b00, 1'b1);
    en_we = 1'b1; en_din = 2'b11; step(); exp_n("level_enabled", 2'b00, 1'b1);
    en_we = 1'b0; step(); exp_n("level_hold", 2'b00, 1'b1);

    src = 2'b00; en_we = 1'b1; en_din = 2'b01; step();
    en_we = 1'b0; src = 2'b11; step(); exp_n("mask_set", 2'b01, 1'b0);
    src = 2'b00; step(); exp_n("mask_hold", 2'b01, 1'b0);
    ack = 2'b01; step(); exp_n("ack_clear", 2'b00, 1'b1);
    src = 2'b01; step(); exp_n("edge_beats_ack", 2'b01, 1'b0);
    src = 2'b00; ack = 2'b00; step(); exp_n("edge_ack_hold", 2'b01, 1'b0);

    en_we = 1'b1; en_din = 2'b00; step(); exp_n("disable_clear", 2'b00, 1'b1);
    en_we = 1'b0; src = 2'b01; step(); exp_n("disable_block", 2'b00, 1'b1);
    src = 2'b00; step();
    en_we = 1'b1; en_din = 2'b10; src = 2'b10; step(); exp_n("write_then_set", 2'b10, 1'b0);
    en_we = 1'b0; src = 2'b00; ack = 2'b10; step(); exp_n("ack_src1", 2'b00, 1'b1);
    ack = 2'b00;

    wd_en = 1'b1; step(); exp_w("wd_enter", 4'd0, 1'b0);
    pulse_tick(); exp_w("tick_one", 4'd1, 1'b0);
    cen = 1'b0; tick = 1'b1; step(); tick = 1'b0; step(); cen = 1'b1;
    exp_w("cen_gates_tick", 4'd1, 1'b0);
    wd_en = 1'b0; step(); exp_w("wd_off", 4'd0, 1'b0);
    wd_en = 1'b1; step();

    repeat (15) pulse_tick();
    exp_w("cnt15", 4'd15, 1'b0);
    kick = 1'b1; tick = 1'b1; step(); exp_w("kick_beats_tick", 4'd0, 1'b0);
    kick = 1'b0; tick = 1'b0; step();
    repeat (15) pulse_tick();
    kick = 1'b1; step(); exp_w("kick_at15", 4'd0, 1'b0);
    kick = 1'b0;

    repeat (15) pulse_tick();
    exp_w("cnt15_b", 4'd15, 1'b0);
    tick = 1'b1; step(); exp_w("overflow", 4'd0, 1'b1);
    tick = 1'b0; src = 2'b10; step(); exp_w("pulse2", 4'd0, 1'b1);
    exp_n("pulse_no_nmi", 2'b00, 1'b1);
    step(); exp_w("pulse3", 4'd0, 1'b1);
    step(); exp_w("pulse_end", 4'd0, 1'b0);
    src = 2'b00; step();
    src = 2'b10; step(); exp_n("enable_cleared", 2'b00, 1'b1);
    src = 2'b00;

    repeat (15) pulse_tick();
    tick = 1'b1; step(); exp_w("ovf_rst_1", 4'd0, 1'b1);
    tick = 1'b0; step(); exp_w("ovf_rst_2", 4'd0, 1'b1);
    rst = 1'b1; step(); exp_w("rst_abort", 4'd0, 1'b0);
    rst = 1'b0; step(); step(); exp_w("after_abort", 4'd0, 1'b0);

    repeat (15) pulse_tick();
    tick = 1'b1; step(); exp_w("cen0_p1", 4'd0, 1'b1);
    cen = 1'b0; tick = 1'b0;
    step(); exp_w("cen0_p2", 4'd0, 1'b1);
    step(); exp_w("cen0_p3", 4'd0, 1'b1);
    step(); exp_w("cen0_end", 4'd0, 1'b0);
    cen = 1'b1;

    repeat (4) step();
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
